// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low hex keypad one column at a time,
// debounces whole-keypad snapshots across several scan frames and collects
// single-key presses into a four-digit entry word with a valid/ack handoff.
module keypad_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  input  logic        clr,
  input  logic        value_ack,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] entry,
  output logic [2:0]  digit_cnt,
  output logic        value_valid
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE);

  // True when exactly one key is down in the map.
  function automatic logic is_onehot(input logic [15:0] m);
    return (m != 16'h0000) && ((m & (m - 16'h0001)) == 16'h0000);
  endfunction

  // Index of the lowest set bit; only used on one-hot maps.
  function automatic logic [3:0] encode(input logic [15:0] m);
    logic [3:0] idx;
    idx = 4'h0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  logic [3:0]    row_meta_q, row_sync_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [3:0]    col_out_q, col_out_d;
  logic [15:0]   frame_q, frame_d, frame_full_s;
  logic [15:0]   prev_q, prev_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [15:0]   deb_q, deb_d;
  logic          tick_s, frame_end_s, load_s, event_s;
  logic [3:0]    code_s;

  logic          key_valid_q, key_valid_d;
  logic [3:0]    key_code_q, key_code_d;
  logic [15:0]   entry_q, entry_d;
  logic [2:0]    digit_cnt_q, digit_cnt_d;
  logic          value_valid_q, value_valid_d;

  // Prescaler, column rotation, frame assembly and frame-level debounce.
  always_comb begin
    tick_s       = (presc_q == PRESC_MAX);
    presc_d      = tick_s ? '0 : presc_q + PW'(1);
    col_idx_d    = tick_s ? col_idx_q + 2'd1 : col_idx_q;
    case (col_idx_d)
      2'd0:    col_out_d = 4'b1110;
      2'd1:    col_out_d = 4'b1101;
      2'd2:    col_out_d = 4'b1011;
      2'd3:    col_out_d = 4'b0111;
      default: col_out_d = 4'b1110;
    endcase
    frame_full_s = frame_q;
    frame_full_s[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
    frame_d      = tick_s ? frame_full_s : frame_q;
    frame_end_s  = tick_s && (col_idx_q == 2'd3);
    stable_d     = stable_q;
    prev_d       = prev_q;
    if (frame_end_s) begin
      if (frame_full_s == prev_q) begin
        stable_d = (stable_q == STABLE_MAX) ? STABLE_MAX : stable_q + SW'(1);
      end else begin
        stable_d = SW'(1);
      end
      prev_d = frame_full_s;
    end else begin
      stable_d = stable_q;
    end
    load_s  = frame_end_s && (stable_d == STABLE_MAX);
    deb_d   = load_s ? frame_full_s : deb_q;
    event_s = load_s && (deb_q == 16'h0000) && is_onehot(frame_full_s);
    code_s  = encode(frame_full_s);
  end

  // Entry word, digit count and value handshake; clr has top priority.
  always_comb begin
    key_valid_d   = event_s;
    key_code_d    = event_s ? code_s : key_code_q;
    entry_d       = entry_q;
    digit_cnt_d   = digit_cnt_q;
    value_valid_d = value_valid_q;
    if (clr) begin
      entry_d       = 16'h0000;
      digit_cnt_d   = 3'd0;
      value_valid_d = 1'b0;
    end else if (value_valid_q && value_ack) begin
      value_valid_d = 1'b0;
      if (event_s) begin
        entry_d     = {12'h000, code_s};
        digit_cnt_d = 3'd1;
      end else begin
        entry_d     = 16'h0000;
        digit_cnt_d = 3'd0;
      end
    end else if (event_s && !value_valid_q) begin
      entry_d       = {entry_q[11:0], code_s};
      digit_cnt_d   = digit_cnt_q + 3'd1;
      value_valid_d = (digit_cnt_q == 3'd3);
    end else begin
      entry_d = entry_q;
    end
  end

  // Row synchronizer and scan/debounce state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      presc_q    <= '0;
      col_idx_q  <= 2'd0;
      col_out_q  <= 4'b1110;
      frame_q    <= 16'h0000;
      prev_q     <= 16'h0000;
      stable_q   <= '0;
      deb_q      <= 16'h0000;
    end else begin
      row_meta_q <= row_in;
      row_sync_q <= row_meta_q;
      presc_q    <= presc_d;
      col_idx_q  <= col_idx_d;
      col_out_q  <= col_out_d;
      frame_q    <= frame_d;
      prev_q     <= prev_d;
      stable_q   <= stable_d;
      deb_q      <= deb_d;
    end
  end

  // Registered key and entry outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid_q   <= 1'b0;
      key_code_q    <= 4'h0;
      entry_q       <= 16'h0000;
      digit_cnt_q   <= 3'd0;
      value_valid_q <= 1'b0;
    end else begin
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      entry_q       <= entry_d;
      digit_cnt_q   <= digit_cnt_d;
      value_valid_q <= value_valid_d;
    end
  end

  assign col_out     = col_out_q;
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign entry       = entry_q;
  assign digit_cnt   = digit_cnt_q;
  assign value_valid = value_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=2.
// A small keypad model pulls rows low for pressed keys in the driven column.
// cyc counts rising edges since reset release, so a frame ends every 16 edges.
module tb_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        clr;
  logic        value_ack;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] entry;
  logic [2:0]  digit_cnt;
  logic        value_valid;

  logic [15:0] pressed;
  int          cyc;
  int          kv_count;
  int          checks;
  int          passed;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
    .clr(clr), .value_ack(value_ack), .key_valid(key_valid),
    .key_code(key_code), .entry(entry), .digit_cnt(digit_cnt),
    .value_valid(value_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: row r reads low when a pressed key sits in a driven column.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (pressed[c*4+r] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  // Edge counter aligned with the DUT's prescaler.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Count high cycles of key_valid.
  initial kv_count = 0;
  always @(negedge clk) begin
    if (rst_n && key_valid === 1'b1) kv_count <= kv_count + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Press key k at a frame boundary, check the event 2 frames later,
  // then release and wait until the debounced map is back to all-zero.
  task automatic press_key(input logic [3:0] k, input bit ack_at_event,
                           input logic [15:0] exp_entry, input logic [2:0] exp_cnt,
                           input logic exp_vv);
    int base;
    base = cyc;
    pressed = 16'h0001 << k;
    if (ack_at_event) begin
      wait_cyc(base + 31);
      value_ack = 1'b1;
    end
    wait_cyc(base + 32);
    value_ack = 1'b0;
    check("kv_pulse", key_valid, 1'b1);
    check("key_code", key_code, k);
    check("entry", entry, exp_entry);
    check("digit_cnt", digit_cnt, exp_cnt);
    check("value_valid", value_valid, exp_vv);
    wait_cyc(base + 33);
    check("kv_one_cycle", key_valid, 1'b0);
    pressed = 16'h0000;
    wait_cyc(base + 64);
  endtask

  initial begin
    checks = 0; passed = 0;
    rst_n = 1'b0; clr = 1'b0; value_ack = 1'b0; pressed = 16'h0000;

    // Reset state
    #12;
    check("rst_col", col_out, 4'b1110);
    check("rst_kv", key_valid, 1'b0);
    check("rst_code", key_code, 4'h0);
    check("rst_entry", entry, 16'h0000);
    check("rst_cnt", digit_cnt, 3'd0);
    check("rst_vv", value_valid, 1'b0);
    #10 rst_n = 1'b1;

    // Idle column rotation, 4 clocks per step
    check("col_c0", col_out, 4'b1110);
    wait_cyc(3);  check("col_c3", col_out, 4'b1110);
    wait_cyc(4);  check("col_c4", col_out, 4'b1101);
    wait_cyc(8);  check("col_c8", col_out, 4'b1011);
    wait_cyc(12); check("col_c12", col_out, 4'b0111);
    wait_cyc(16); check("col_c16", col_out, 4'b1110);
    wait_cyc(32);
    check("idle_kv", kv_count, 0);
    check("idle_entry", entry, 16'h0000);

    // Clean press of key 6 held 4 frames
    pressed = 16'h0040;
    wait_cyc(63); check("k6_early", key_valid, 1'b0);
    wait_cyc(64);
    check("k6_kv", key_valid, 1'b1);
    check("k6_code", key_code, 4'h6);
    check("k6_entry", entry, 16'h0006);
    check("k6_cnt", digit_cnt, 3'd1);
    wait_cyc(65); check("k6_kv_low", key_valid, 1'b0);
    wait_cyc(96); check("k6_pulses", kv_count, 1);
    pressed = 16'h0000;
    wait_cyc(128); check("k6_release", kv_count, 1);

    // One-frame glitch on key 5, then a two-key hold of 1 and A
    pressed = 16'h0020;
    wait_cyc(144); pressed = 16'h0000;
    wait_cyc(176); pressed = 16'h0402;
    wait_cyc(240); pressed = 16'h0000;
    wait_cyc(272);
    check("glitch_multi_kv", kv_count, 1);
    check("glitch_entry", entry, 16'h0006);

    // Clear, then enter 1,2,3,4
    clr = 1'b1; wait_cyc(273); clr = 1'b0;
    check("clr1_entry", entry, 16'h0000);
    wait_cyc(288);
    press_key(4'h1, 1'b0, 16'h0001, 3'd1, 1'b0);
    press_key(4'h2, 1'b0, 16'h0012, 3'd2, 1'b0);
    press_key(4'h3, 1'b0, 16'h0123, 3'd3, 1'b0);
    press_key(4'h4, 1'b0, 16'h1234, 3'd4, 1'b1);
    // 5th press while full: entry frozen
    press_key(4'hF, 1'b0, 16'h1234, 3'd4, 1'b1);
    value_ack = 1'b1; wait_cyc(609); value_ack = 1'b0;
    check("ack_vv", value_valid, 1'b0);
    check("ack_entry", entry, 16'h0000);
    check("ack_cnt", digit_cnt, 3'd0);
    wait_cyc(624);

    // Fill again, then ack coincident with key 9
    press_key(4'hA, 1'b0, 16'h000A, 3'd1, 1'b0);
    press_key(4'hB, 1'b0, 16'h00AB, 3'd2, 1'b0);
    press_key(4'hC, 1'b0, 16'h0ABC, 3'd3, 1'b0);
    press_key(4'hD, 1'b0, 16'hABCD, 3'd4, 1'b1);
    press_key(4'h9, 1'b1, 16'h0009, 3'd1, 1'b0);

    // value_ack ignored while value_valid is low
    value_ack = 1'b1; wait_cyc(945); value_ack = 1'b0;
    check("ack_ign_entry", entry, 16'h0009);
    check("ack_ign_cnt", digit_cnt, 3'd1);

    // clr with entry 00AB
    clr = 1'b1; wait_cyc(946); clr = 1'b0;
    wait_cyc(960);
    press_key(4'hA, 1'b0, 16'h000A, 3'd1, 1'b0);
    press_key(4'hB, 1'b0, 16'h00AB, 3'd2, 1'b0);
    clr = 1'b1; wait_cyc(1089); clr = 1'b0;
    check("clr_entry", entry, 16'h0000);
    check("clr_cnt", digit_cnt, 3'd0);

    // Asynchronous reset mid-frame with a key held and a digit entered
    wait_cyc(1104);
    pressed = 16'h0008;
    wait_cyc(1136);
    check("k3_kv", key_valid, 1'b1);
    check("k3_entry", entry, 16'h0003);
    wait_cyc(1140);
    #3 rst_n = 1'b0;
    #1;
    check("arst_col", col_out, 4'b1110);
    check("arst_kv", key_valid, 1'b0);
    check("arst_code", key_code, 4'h0);
    check("arst_entry", entry, 16'h0000);
    check("arst_cnt", digit_cnt, 3'd0);
    check("arst_vv", value_valid, 1'b0);
    pressed = 16'h0000;
    #21 rst_n = 1'b1;
    check("restart_c0", col_out, 4'b1110);
    wait_cyc(4); check("restart_c4", col_out, 4'b1101);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Input-side counterpart of the board's multiplexed 7-segment display driver. Drives a 4x4 hex keypad with a rotating active-low column select, debounces the returned rows, and assembles pressed hex digits into a 16-bit entry word. The entry word feeds the display register inputs for live echo. A completed 4-digit value is handed to the core over a valid/ack handshake.

## Interface
- SCAN_DIV, 1000: clocks per column step; must be ≥4.
- DEBOUNCE, 4: consecutive identical scan frames required to accept a key map; must be ≥1.

Ports:
- clk  in  1: system clock; the block uses this single clock, rising edge.
- rst_n  in  1: reset; asynchronous, active-low.
- row_in  in  4: keypad rows, active-low (bit i low = row i closed), asynchronous to clk.
- col_out  out  4: column drive, active-low one-hot.
- clr  in  1: synchronous clear of entry state.
- value_ack  in  1: consumer accepts the current value.
- key_valid  out  1: one-cycle pulse per accepted key press.
- key_code  out  4: code of last accepted key.
- entry  out  16: digits entered so far; newest digit in [3:0].
- digit_cnt  out  3: digits entered, 0..4.
- value_valid  out  1: 4 digits complete, entry held stable.

## Operation
- Reset values: col_out=4'b1110, key_valid=0, key_code=0, entry=0, digit_cnt=0, value_valid=0. Internal prescaler, frame map, previous map, stable count and debounced map are all 0.
- row_in passes through a 2-flop synchronizer before any use.
- Prescaler counts 0..SCAN_DIV-1. The tick fires on the cycle it equals SCAN_DIV-1, then the prescaler wraps to 0.
- On tick:
  - Sample the synchronized rows for the current column into the frame map. Key index = col*4 + row, where col = position of the low bit in col_out.
  - Advance col_out 1110→1101→1011→0111→1110.
- Frame end is the tick that samples column 3. At frame end:
  - If the frame map equals the previous map, stable count increments, saturating at DEBOUNCE. Otherwise stable count is set to 1.
  - Previous map is loaded with the frame map.
  - When stable count reaches DEBOUNCE on this frame, the debounced map is loaded with the frame map.
- Press event: on a debounced-map update where the old map was all-zero and the new map has exactly one bit set. key_code is set to that bit's index (0x0..0xF).
  - More than one key set: no event. Another event requires return to all-released.
  - Releases never generate events.
- On a press event:
  - key_valid pulses.
  - If value_valid=0: entry ← {entry[11:0], code}, digit_cnt+1.
  - When digit_cnt becomes 4, value_valid ← 1.
  - If value_valid=1: key_valid/key_code still update; entry and digit_cnt are frozen.
- value_ack is honoured only while value_valid=1. It sets value_valid←0, entry←0, digit_cnt←0. It is ignored while value_valid=0.
- Priority per cycle:
  - clr beats everything: entry=0, digit_cnt=0, value_valid=0, no shift. key_valid/key_code still pulse and update if an event coincides.
  - value_ack and a press event in the same cycle: entry←{12'h000,code}, digit_cnt←1, value_valid←0.

## Timing
- Column step = SCAN_DIV clocks. Frame = 4·SCAN_DIV clocks.
- Row sampling latency: 2 synchronizer cycles. The rows see each column for SCAN_DIV clocks before sampling.
- Press latency: a press stable across frames k..k+DEBOUNCE-1 updates the debounced map at the frame-end tick of frame k+DEBOUNCE-1.
- key_valid, key_code, entry, digit_cnt and value_valid change on the next clock edge after that tick. key_valid is high for exactly one cycle.
- value_valid rises in the same cycle as the 4th key_valid. It stays high until the cycle after value_ack is sampled high.
- rst_n low at any time, including mid-frame or mid-entry, forces all reset values immediately.

## Test plan
Parameters for all scenarios: SCAN_DIV=4, DEBOUNCE=2.

- Idle after reset, rows all 1:
  - col_out cycles 1110,1101,1011,0111 with 4 clocks per step.
  - key_valid never asserts; entry=0.
- Clean press of key 0x6 (row 2 low while col_out=1101) held 4 frames:
  - One key_valid pulse, key_code=6, entry=16'h0006, digit_cnt=1.
  - The pulse lands one clock after the 2nd frame-end tick of the stable press.
- Key 0x5 bouncing 1-frame glitch then released:
  - No key_valid.
  - A two-key hold of 0x1 and 0xA also gives no key_valid.
- Enter digits 1,2,3,4 with releases between:
  - entry=16'h1234, digit_cnt=4, value_valid=1.
  - A 5th press of 0xF: key_valid pulses, key_code=F, entry stays 16'h1234.
  - Then value_ack: value_valid=0, entry=0.
- value_ack coincident with a key 0x9 event while value_valid=1: entry=16'h0009, digit_cnt=1, value_valid=0.
- Mid-entry controls:
  - clr with entry=16'h00AB: entry=0, digit_cnt=0.
  - rst_n pulsed low mid-frame: every output returns to its reset value asynchronously.
  - After rst_n release, col_out restarts at 1110.
